// File: rtl/cpu_run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_run_ctrl : run/halt/single-step controller producing the datapath      |
// |                clock enable, with stop causes and a retired-inst counter.  |
// | Optional feature macro: RUN_CTRL_BP_EN (breakpoint comparator).            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cpu_run_ctrl #(
    parameter int          PC_W      = 32,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [7:0]       step_n,
    input  logic [PC_W-1:0]  pc,
    input  logic [31:0]      inst,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [2:0]       halt_cause,
    output logic             cmd_err,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [1:0] ST_HALT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_STEP = 2'b10;

    localparam logic [1:0] OP_HALT = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam logic [2:0] CAUSE_RESET = 3'd0;
    localparam logic [2:0] CAUSE_HOST  = 3'd1;
    localparam logic [2:0] CAUSE_STEP  = 3'd2;
    localparam logic [2:0] CAUSE_BREAK = 3'd3;
    localparam logic [2:0] CAUSE_HINST = 3'd4;

    logic [7:0] r_remaining;
    logic       w_active;
    logic       w_halt_inst;
    logic       w_bp_hit;
    logic       w_step_done;
    logic       w_start;

    assign cmd_ready   = 1'b1;
    assign w_active    = (state != ST_HALT);
    assign w_halt_inst = (inst == HALT_INST);
    assign w_start     = (state == ST_HALT) && cmd_valid &&
                         ((cmd_op == OP_RUN) || (cmd_op == OP_STEP));

`ifdef RUN_CTRL_BP_EN
    // Disarmed on entry so a resume from the breakpoint PC executes that instruction.
    logic r_bp_armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bp_armed <= 1'b0;
        end else if (w_start) begin
            r_bp_armed <= 1'b0;
        end else if (cpu_en) begin
            r_bp_armed <= 1'b1;
        end
    end

    assign w_bp_hit = bp_en && r_bp_armed && (pc == bp_addr);
`else
    logic unused_bp;
    assign unused_bp = ^{bp_en, bp_addr};
    assign w_bp_hit  = 1'b0;
`endif

    assign cpu_en      = w_active && !w_halt_inst && !w_bp_hit;
    assign w_step_done = (state == ST_STEP) && cpu_en && (r_remaining == 8'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_HALT;
            halt_cause  <= CAUSE_RESET;
            cmd_err     <= 1'b0;
            r_remaining <= 8'd0;
            retired_cnt <= '0;
        end else begin
            cmd_err <= 1'b0;
            if (state == ST_HALT) begin
                if (cmd_valid && (cmd_op == OP_RUN)) begin
                    state <= ST_RUN;
                end else if (cmd_valid && (cmd_op == OP_STEP)) begin
                    state       <= ST_STEP;
                    r_remaining <= (step_n == 8'd0) ? 8'd1 : step_n;
                end
            end else begin
                if ((state == ST_STEP) && cpu_en) begin
                    r_remaining <= r_remaining - 8'd1;
                end
                if (cmd_valid && ((cmd_op == OP_RUN) || (cmd_op == OP_STEP))) begin
                    cmd_err <= 1'b1;
                end
                // Stop-cause priority: HALT instruction, breakpoint, step done, host.
                if (w_halt_inst) begin
                    state      <= ST_HALT;
                    halt_cause <= CAUSE_HINST;
                end else if (w_bp_hit) begin
                    state      <= ST_HALT;
                    halt_cause <= CAUSE_BREAK;
                end else if (w_step_done) begin
                    state      <= ST_HALT;
                    halt_cause <= CAUSE_STEP;
                end else if (cmd_valid && (cmd_op == OP_HALT)) begin
                    state      <= ST_HALT;
                    halt_cause <= CAUSE_HOST;
                end
            end
            if (cmd_valid && (cmd_op == OP_CLR)) begin
                retired_cnt <= '0;
            end else if (cpu_en) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/halt/single-step controller for the single-cycle CPU datapath. It generates the datapath clock enable `cpu_en`, so the host or bench can halt, run freely or step N instructions. It stops on a breakpoint PC, a HALT instruction or a host command, and counts retired instructions. It sits between the CPU top and the host/bench, observing the current PC and instruction.

## Interface
- `PC_W`, 32, PC/breakpoint width
- `CNT_W`, 32, retired-instruction counter width
- `HALT_INST`, 32'hFFFF_FFFF, instruction encoding that halts the core
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `cmd_valid` in 1: host command valid
- `cmd_ready` out 1: host command ready, tied 1
- `cmd_op` in 2: 00 HALT, 01 RUN, 10 STEP, 11 CLR_CNT
- `step_n` in 8: instruction count for STEP; 0 is treated as 1
- `pc` in PC_W: current datapath PC
- `inst` in 32: instruction at `pc`
- `bp_en` in 1: breakpoint enable
- `bp_addr` in PC_W: breakpoint PC
- `cpu_en` out 1: datapath update enable (combinational from state/inputs)
- `state` out 2: 00 HALT, 01 RUN, 10 STEP
- `halt_cause` out 3: 0 RESET, 1 HOST, 2 STEP_DONE, 3 BREAK, 4 HALT_INST
- `cmd_err` out 1: one-cycle pulse, RUN/STEP received while not halted
- `retired_cnt` out CNT_W: instructions retired

## Operation
- Reset values: `state`=HALT, `halt_cause`=RESET, `retired_cnt`=0, `cmd_err`=0, `cpu_en`=0, remaining-step counter=0, `bp_armed`=0.
- A command is accepted on any edge where `cmd_valid`=1.
- HALT state:
  - RUN: go to RUN.
  - STEP: load remaining = max(`step_n`,1), then go to STEP.
  - HALT: no effect.
- RUN/STEP state:
  - HALT: go to HALT, cause HOST.
  - RUN/STEP: ignored; pulse `cmd_err`.
- CLR_CNT is valid in any state.
- A retire is any cycle with `cpu_en`=1. `retired_cnt` increments by 1 per retire and wraps modulo 2^CNT_W.
- `cpu_en`=1 only in RUN/STEP, and only when no stop condition holds in that cycle. Stop conditions:
  - `inst`==`HALT_INST`: do not retire; go to HALT, cause HALT_INST.
  - Breakpoint: `bp_en` and `bp_armed` and `pc`==`bp_addr`. Do not retire; go to HALT, cause BREAK.
- `bp_armed` is cleared on entry to RUN/STEP and set after the first retire. This lets a resume from a breakpoint PC execute that instruction.
- STEP: each retire decrements remaining. A retire with remaining==1 goes to HALT, cause STEP_DONE.
- Stop-cause priority within one cycle: HALT_INST > BREAK > STEP_DONE > HOST.
- A host HALT does not gate `cpu_en` in the cycle it is accepted; that instruction still retires.
- `halt_cause` updates only on a transition into HALT. It holds while halted.

## Timing
- Command accepted at edge k: new `state` visible after edge k. In the RUN case, the first `cpu_en`=1 can occur in cycle k+1.
- STEP N from halt: exactly N consecutive `cpu_en` cycles, absent other stops. `state`=HALT in the cycle after the Nth retire.
- Stop conditions gate `cpu_en` combinationally in the same cycle. `state` becomes HALT after the next edge.
- CLR_CNT coinciding with a retire: the counter becomes 0 (clear wins).
- `rst` low at any time: `state`, `cpu_en` and all outputs go to reset values immediately, without waiting for a clock edge. Release is synchronous to the next edge.
- A HALT instruction re-halts immediately on RUN. The host must redirect the PC to proceed.

## Configuration
- `RUN_CTRL_BP_EN` defined: breakpoint comparator and `bp_armed` logic are compiled in, as described above.
- Not defined: `bp_en`/`bp_addr` remain as ports but are ignored. No comparator is built, and cause BREAK never occurs.

## Test plan
- Reset with `rst`=0, then release:
  - `state`=00, `halt_cause`=0, `cpu_en`=0 and `retired_cnt`=0 until a command arrives.
- STEP with `step_n`=3, `inst`=NOP:
  - `cpu_en` high for exactly 3 cycles, then `state`=HALT, `halt_cause`=2, `retired_cnt`=3.
  - A further STEP with `step_n`=0 retires exactly 1.
- RUN with `bp_en`=1, `bp_addr`=0x10, PC advancing by 4 from 0:
  - 4 retires, `cpu_en`=0 at `pc`=0x10, `halt_cause`=3.
  - A following STEP with `step_n`=1 retires the instruction at 0x10.
- RUN, then `inst`=32'hFFFF_FFFF at cycle 5:
  - 5 retires, `cpu_en` low in that cycle, cause 4.
  - A new RUN with `inst` unchanged causes 0 retires.
- Host HALT accepted during RUN:
  - The instruction in the accept cycle retires; cause 1.
  - A RUN sent while in RUN gives a `cmd_err` pulse and no state change.
- CLR_CNT on a retire cycle gives `retired_cnt`=0.
- `rst` asserted mid-STEP gives `cpu_en`=0 before the next edge.
- Counter preset to all-ones plus one retire wraps to 0.
